// File: rtl/cu_param_pkg.sv
// ============================================================================
// Module      : cu_pkg
// Description : Shared opcodes, FSM states, bus-select and ALU constants for
//               the parametrised multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    typedef enum logic [2:0] {
        OP_MOV  = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EX1   = 3'd1,
        ST_EX2   = 3'd2,
        ST_EX3   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [1:0] BUS_REG  = 2'b00;
    localparam logic [1:0] BUS_G    = 2'b01;
    localparam logic [1:0] BUS_EXT  = 2'b10;
    localparam logic [1:0] BUS_NONE = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // Non-ALU opcodes map to ADD, which is also the idle encoding.
    function automatic logic [2:0] alu_op_of(input opcode_e op);
        logic [2:0] r;
        case (op)
            OP_ADD:  r = ALU_ADD;
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            OP_OR:   r = ALU_OR;
            OP_XOR:  r = ALU_XOR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cu_param_if.sv
// ============================================================================
// Module      : cu_param_if
// Description : Fetch handshake and datapath control bundle of cu_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cu_param_if #(
    parameter int NREG = 8
);
    localparam int RA_W = $clog2(NREG);
    localparam int IW   = 3 + 2 * RA_W;

    logic            instr_valid;
    logic [IW-1:0]   instr;
    logic            instr_ready;
    logic            resume;
    logic [1:0]      bus_src;
    logic [RA_W-1:0] bus_reg;
    logic            a_en;
    logic            g_en;
    logic [2:0]      alu_op;
    logic [NREG-1:0] reg_en;
    logic            done;
    logic            halted;

    // Master is the instruction source / datapath side; slave is the CU.
    modport master (
        output instr_valid, instr, resume,
        input  instr_ready, bus_src, bus_reg, a_en, g_en, alu_op,
               reg_en, done, halted
    );

    modport slave (
        input  instr_valid, instr, resume,
        output instr_ready, bus_src, bus_reg, a_en, g_en, alu_op,
               reg_en, done, halted
    );

endinterface

`default_nettype wire

// File: rtl/cu_param.sv
// ============================================================================
// Module      : cu_param
// Description : Multi-cycle control unit sequencing the register-file/ALU
//               datapath from a fetched instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_param
    import cu_pkg::*;
#(
    parameter int NREG = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    cu_param_if.slave cif
);

    localparam int RA_W = $clog2(NREG);
    localparam int IW   = 3 + 2 * RA_W;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [IW-1:0]   r_ir;

    opcode_e         w_op;
    logic [RA_W-1:0] w_dest;
    logic [RA_W-1:0] w_src;
    logic [NREG-1:0] w_dest_oh;

    logic            w_ready;
    logic [1:0]      w_bus_src;
    logic [RA_W-1:0] w_bus_reg;
    logic            w_a_en;
    logic            w_g_en;
    logic [2:0]      w_alu_op;
    logic [NREG-1:0] w_reg_en;
    logic            w_done;
    logic            w_halted;

    assign w_op      = opcode_e'(r_ir[IW-1:IW-3]);
    assign w_dest    = r_ir[2*RA_W-1:RA_W];
    assign w_src     = r_ir[RA_W-1:0];
    assign w_dest_oh = {{(NREG-1){1'b0}}, 1'b1} << w_dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ready && cif.instr_valid) begin
                r_ir <= cif.instr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_bus_src   = BUS_NONE;
        w_bus_reg   = '0;
        w_a_en      = 1'b0;
        w_g_en      = 1'b0;
        w_alu_op    = ALU_ADD;
        w_reg_en    = '0;
        w_done      = 1'b0;
        w_halted    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_ready = 1'b1;
                if (cif.instr_valid) begin
                    w_state_nxt = ST_EX1;
                end
            end
            ST_EX1: begin
                case (w_op)
                    OP_MOV: begin
                        w_bus_src   = BUS_REG;
                        w_bus_reg   = w_src;
                        w_reg_en    = w_dest_oh;
                        w_done      = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    OP_MVI: begin
                        w_bus_src   = BUS_EXT;
                        w_reg_en    = w_dest_oh;
                        w_done      = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    OP_HALT: begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_HALT;
                    end
                    default: begin
                        // Two-operand ops first latch the destination into A.
                        w_bus_src   = BUS_REG;
                        w_bus_reg   = w_dest;
                        w_a_en      = 1'b1;
                        w_state_nxt = ST_EX2;
                    end
                endcase
            end
            ST_EX2: begin
                w_bus_src   = BUS_REG;
                w_bus_reg   = w_src;
                w_alu_op    = alu_op_of(w_op);
                w_g_en      = 1'b1;
                w_state_nxt = ST_EX3;
            end
            ST_EX3: begin
                w_bus_src   = BUS_G;
                w_reg_en    = w_dest_oh;
                w_done      = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (cif.resume) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    assign cif.instr_ready = w_ready;
    assign cif.bus_src     = w_bus_src;
    assign cif.bus_reg     = w_bus_reg;
    assign cif.a_en        = w_a_en;
    assign cif.g_en        = w_g_en;
    assign cif.alu_op      = w_alu_op;
    assign cif.reg_en      = w_reg_en;
    assign cif.done        = w_done;
    assign cif.halted      = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_cu_param.sv
// ============================================================================
// Module      : tb_cu_param
// Description : Self-checking bench for cu_param: cycle tables, corner-case
//               sequences and random instructions on a modelled datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cu_param;

    localparam int NREG = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cu_param_if #(.NREG(NREG)) cif();

    cu_param #(.NREG(NREG)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cif   (cif)
    );

    // Datapath driven by the CU controls: register file, A, G, ALU.
    logic [7:0] regs [NREG] = '{default: 8'h00};
    logic [7:0] a_q  = 8'h00;
    logic [7:0] g_q  = 8'h00;
    logic [7:0] ext_data;
    logic [7:0] bus_v;

    always_comb begin
        case (cif.bus_src)
            2'b00:   bus_v = regs[cif.bus_reg];
            2'b01:   bus_v = g_q;
            2'b10:   bus_v = ext_data;
            default: bus_v = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (cif.a_en) a_q <= bus_v;
        if (cif.g_en) begin
            case (cif.alu_op)
                3'b000:  g_q <= a_q + bus_v;
                3'b001:  g_q <= a_q - bus_v;
                3'b010:  g_q <= a_q & bus_v;
                3'b011:  g_q <= a_q | bus_v;
                3'b100:  g_q <= a_q ^ bus_v;
                default: g_q <= 8'hxx;
            endcase
        end
        for (int i = 0; i < NREG; i++) begin
            if (cif.reg_en[i]) regs[i] <= bus_v;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_regs [NREG];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [20:0] exw(input logic rdy, input logic [1:0] bs,
                                        input logic [2:0] br, input logic a,
                                        input logic g, input logic [2:0] op,
                                        input logic [7:0] en, input logic d,
                                        input logic h);
        return {rdy, bs, br, a, g, op, en, d, h};
    endfunction

    function automatic logic [20:0] outw();
        return {cif.instr_ready, cif.bus_src, cif.bus_reg, cif.a_en, cif.g_en,
                cif.alu_op, cif.reg_en, cif.done, cif.halted};
    endfunction

    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] d,
                                              input logic [7:0] s, input logic [7:0] ext);
        case (op)
            3'd0:    return s;
            3'd1:    return ext;
            3'd2:    return d + s;
            3'd3:    return d - s;
            3'd4:    return d & s;
            3'd5:    return d | s;
            default: return d ^ s;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("%s_r%0d", tag, i), 32'(regs[i]), 32'(exp_regs[i]));
        end
    endtask

    // Issue one non-HALT instruction, check latency and the resulting registers.
    task automatic issue(input logic [8:0] ins, input logic [7:0] ext);
        int n;
        logic [2:0] op, d, s;
        op = ins[8:6];
        d  = ins[5:3];
        s  = ins[2:0];
        ext_data = ext;
        n = 0;
        while (!cif.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_ready", 32'(cif.instr_ready), 32'd1);
        cif.instr_valid = 1'b1;
        cif.instr       = ins;
        @(negedge clk);
        cif.instr_valid = 1'b0;
        cif.instr       = 9'($urandom);
        n = 1;
        while (!cif.done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency_op%0d", op), 32'(n + 1),
            (op >= 3'd2 && op <= 3'd6) ? 32'd4 : 32'd2);
        exp_regs[d] = ref_result(op, exp_regs[d], exp_regs[s], ext);
        @(negedge clk);
        check_regs($sformatf("op%0d_d%0d_s%0d", op, d, s));
    endtask

    typedef struct {
        logic        v;
        logic [8:0]  ins;
        logic        res;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] idle;
        int n, m;

        idle = exw(1'b1, 2'b11, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        tbl[0]  = '{1'b0, 9'b000_000_000, 1'b0, idle};
        tbl[1]  = '{1'b1, 9'b000_011_110, 1'b0, exw(1'b0, 2'b00, 3'd6, 1'b0, 1'b0, 3'd0, 8'h08, 1'b1, 1'b0)};
        tbl[2]  = '{1'b0, 9'b000_000_000, 1'b0, idle};
        tbl[3]  = '{1'b1, 9'b001_000_000, 1'b0, exw(1'b0, 2'b10, 3'd0, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0)};
        tbl[4]  = '{1'b1, 9'b011_010_101, 1'b0, idle};
        tbl[5]  = '{1'b1, 9'b011_010_101, 1'b0, exw(1'b0, 2'b00, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0)};
        tbl[6]  = '{1'b0, 9'b000_111_111, 1'b0, exw(1'b0, 2'b00, 3'd5, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 9'b000_111_111, 1'b0, exw(1'b0, 2'b01, 3'd0, 1'b0, 1'b0, 3'd0, 8'h04, 1'b1, 1'b0)};
        tbl[8]  = '{1'b0, 9'b000_000_000, 1'b0, idle};
        tbl[9]  = '{1'b1, 9'b111_000_000, 1'b0, exw(1'b0, 2'b11, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0)};
        tbl[10] = '{1'b1, 9'b000_001_010, 1'b0, exw(1'b0, 2'b11, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1)};
        tbl[11] = '{1'b1, 9'b000_001_010, 1'b0, exw(1'b0, 2'b11, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1)};
        tbl[12] = '{1'b0, 9'b000_000_000, 1'b1, idle};
        tbl[13] = '{1'b0, 9'b000_000_000, 1'b1, idle};
        tbl[14] = '{1'b0, 9'b000_101_101, 1'b0, idle};

        for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
        cif.instr_valid = 1'b0;
        cif.instr       = '0;
        cif.resume      = 1'b0;
        ext_data        = 8'h00;

        #2;
        chk("reset_state", 32'(outw()), 32'(idle));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cif.instr_valid = tbl[i].v;
            cif.instr       = tbl[i].ins;
            cif.resume      = tbl[i].res;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outw()), 32'(tbl[i].exp));
        end
        cif.instr_valid = 1'b0;
        cif.resume      = 1'b0;
        check_regs("table");

        // Back-to-back XOR R7,R7 then MOV R1,R7 with instr_valid held high.
        issue(9'b001_111_000, 8'h5A);
        issue(9'b001_001_000, 8'h33);
        cif.instr_valid = 1'b1;
        cif.instr       = 9'b110_111_111;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cif.done && n < 10);
        chk("b2b_xor_done_at", 32'(n), 32'd3);
        cif.instr = 9'b000_001_111;
        @(negedge clk);
        chk("b2b_fetch_ready", 32'(cif.instr_ready), 32'd1);
        m = 1;
        while (!cif.done && m < 10) begin
            @(negedge clk);
            m++;
        end
        chk("b2b_done_gap", 32'(m), 32'd2);
        cif.instr_valid = 1'b0;
        exp_regs[7] = 8'h00;
        exp_regs[1] = 8'h00;
        @(negedge clk);
        check_regs("b2b");

        // Reset asserted during EX2 of ADD R4,R3 must abort the write.
        issue(9'b001_100_000, 8'h11);
        issue(9'b001_011_000, 8'h22);
        cif.instr_valid = 1'b1;
        cif.instr       = 9'b010_100_011;
        @(negedge clk);
        cif.instr_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_g_en", 32'(cif.g_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_abort_outputs", 32'(outw()), 32'(idle));
        @(negedge clk);
        chk("reset_hold_outputs", 32'(outw()), 32'(idle));
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_reset_idle", 32'(outw()), 32'(idle));
        check_regs("abort");

        // Random instruction stream against the arithmetic reference.
        for (int k = 0; k < 150; k++) begin
            logic [8:0] ins;
            ins[8:6] = 3'($urandom_range(0, 6));
            ins[5:3] = 3'($urandom_range(0, 7));
            ins[2:0] = 3'($urandom_range(0, 7));
            issue(ins, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cu_param.md
# cu_param

Parametrised multi-cycle control unit for the register-file/ALU datapath. It fetches an instruction over a valid/ready handshake into an internal instruction register. It then sequences the shared bus multiplexer, the A and G register enables, the ALU operation and the per-register write enables. Compared with the fixed 8-register, 4-opcode unit, it adds a configurable register count, eight opcodes (including logic ops and HALT), a fetch handshake, a completion pulse and a proper reset.

## Interface
- NREG, 8, number of general registers; power of two, ≥2. RA_W = $clog2(NREG); IW = 3 + 2*RA_W.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction source has a word on instr.
- instr  in  IW  instruction: [IW-1:IW-3] opcode, [2*RA_W-1:RA_W] dest, [RA_W-1:0] src.
- instr_ready  out  1  CU accepts an instruction this cycle.
- resume  in  1  leaves HALT.
- bus_src  out  2  bus driver: 00 register, 01 G, 10 external data, 11 none.
- bus_reg  out  RA_W  register index when bus_src=00, else 0.
- a_en  out  1  load A from bus.
- g_en  out  1  load G from ALU.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 000 when idle.
- reg_en  out  NREG  one-hot register write enable.
- done  out  1  one-cycle pulse on the last cycle of every instruction.
- halted  out  1  CU is in HALT.

## Operation
- Opcodes: 000 MOV (dest←src), 001 MVI (dest←external data), 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR (dest←dest op src), 111 HALT.
- State machine, states FETCH, EX1, EX2, EX3, HALT:
  - FETCH: instr_ready=1. On instr_valid, capture instr into IR and go to EX1. Otherwise stay.
  - EX1, MOV: bus_src=00, bus_reg=src, reg_en[dest]=1, done=1, then FETCH.
  - EX1, MVI: bus_src=10, reg_en[dest]=1, done=1, then FETCH.
  - EX1, ALU ops: bus_src=00, bus_reg=dest, a_en=1, then EX2.
  - EX1, HALT: all controls idle, done=1, then HALT.
  - EX2: bus_src=00, bus_reg=src, alu_op per opcode, g_en=1, then EX3.
  - EX3: bus_src=01, reg_en[dest]=1, done=1, then FETCH.
  - HALT: halted=1, instr_ready=0. On resume, go to FETCH. resume is ignored in every other state.
- Outputs are a Moore decode of the state and IR. Only one reg_en bit is ever high, and only in the final cycle of an instruction.
- dest==src is legal. ADD R1,R1 doubles R1.
- The IR holds its value until the next fetch handshake.

## Timing
- Reset, asynchronous: state=FETCH, IR=0.
  - Outputs during and after reset: instr_ready=1, bus_src=11, bus_reg=0, a_en=g_en=0, alu_op=000, reg_en=0, done=0, halted=0.
- Reset mid-instruction aborts it: no reg_en and no done for the aborted instruction.
- Latency, counting from the handshake cycle:
  - MOV/MVI take 2 cycles.
  - ALU ops take 4 cycles.
  - HALT takes 2 cycles to reach the HALT state.
- Back-to-back issue: with instr_valid held high, the next handshake occurs in the cycle after done.
- instr is sampled only when instr_valid && instr_ready. Changes on instr at any other time have no effect.
- No output changes while the CU waits in FETCH with instr_valid low.

## Structure
- Shared package cu_pkg holds:
  - the opcode enum (3 bits);
  - the state enum;
  - BUS_REG/BUS_G/BUS_EXT/BUS_NONE constants;
  - the ALU_ADD..ALU_XOR constants, shared with the ALU block.
- Single module; no sub-module. The opcode→alu_op mapping is a package function.

## Test plan
All scenarios use NREG=8, so IW=9.
- Reset then idle: rst_n low mid-ADD at EX2 → next cycle instr_ready=1, reg_en=0, done=0, g_en=0. No write occurs to the dest register.
- MOV R3,R6 (9'b000_011_110) with instr_valid high → cycle+1: bus_src=00, bus_reg=6, reg_en=8'b0000_1000, done=1.
- MVI R0 (9'b001_000_000) → cycle+1: bus_src=10, reg_en=8'b0000_0001, done=1.
- SUB R2,R5 (9'b011_010_101):
  - cycle+1: a_en=1, bus_reg=2;
  - cycle+2: bus_reg=5, alu_op=001, g_en=1;
  - cycle+3: bus_src=01, reg_en=8'b0000_0100, done=1.
- Back-to-back XOR R7,R7 then MOV R1,R7 with instr_valid held high → second handshake in the cycle after the XOR done. The done pulses are 4 cycles apart, then 2.
- HALT (9'b111_000_000):
  - halted=1 and instr_ready=0 from cycle+2, with instr_valid ignored.
  - A one-cycle resume pulse gives instr_ready=1 in the next cycle.
